// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed scanner for the 8x16 minesweeper LED matrix: per-frame map
// snapshot, internal flag blink generator and game-over flash.
module dot_matrix_scanner #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 16,
  parameter int unsigned BLINK_HALF = 555
) (
  input  logic                 div_clk_10k,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] pos,
  input  logic [ROWS*COLS-1:0] twink,
  input  logic                 gameover,
  output logic [ROWS-1:0]      dotR,
  output logic [COLS-1:0]      dotC,
  output logic                 frame_start,
  output logic                 blink
);

  localparam int unsigned SW = $clog2(ROWS + 1);
  localparam int unsigned FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [SW-1:0] BLANK   = SW'(ROWS);
  localparam logic [FW-1:0] FC_LAST = FW'(BLINK_HALF - 1);

  logic [SW-1:0]        s, s_next;
  logic [ROWS*COLS-1:0] pos_s, twink_s;
  logic                 go_s;
  logic [FW-1:0]        fc;
  logic                 snap;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      row_pos, row_twk, col_data;

  // Outputs are decoded from the slot being entered, so registering them adds no latency.
  always_comb begin
    s_next   = (s == BLANK) ? '0 : s + 1'b1;
    snap     = (s_next == BLANK);
    row_pos  = '0;
    row_twk  = '0;
    row_sel  = '1;
    col_data = '0;
    if (!snap) begin
      row_pos = pos_s[COLS*s_next +: COLS];
      row_twk = twink_s[COLS*s_next +: COLS];
      row_sel = ~({1'b1, {(ROWS-1){1'b0}}} >> s_next);
      if (go_s)
        col_data = blink ? '1 : row_pos;
      else
        col_data = row_pos | (blink ? row_twk : '0);
    end
  end

  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      s           <= BLANK;
      pos_s       <= '0;
      twink_s     <= '0;
      go_s        <= 1'b0;
      fc          <= '0;
      blink       <= 1'b0;
      dotR        <= '1;
      dotC        <= '0;
      frame_start <= 1'b0;
    end else begin
      s           <= s_next;
      dotR        <= row_sel;
      dotC        <= col_data;
      frame_start <= (s_next == '0);
      // Blank slot: take the frame snapshot and advance the blink timer together.
      if (snap) begin
        pos_s   <= pos;
        twink_s <= twink;
        go_s    <= gameover;
        if (fc == FC_LAST) begin
          fc    <= '0;
          blink <= ~blink;
        end else begin
          fc <= fc + 1'b1;
        end
      end
    end
  end

endmodule
